// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: 8 blocks x 16 bytes, 1 KiB address space.
// Misses stall the fetch via BUSYWAIT while the whole block is read from memory.
module instruction_cache (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [31:0]  PC,
    output logic [31:0]  INSTRUCTION,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic [5:0]   MEM_ADDRESS,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM_READ,
        S_UPDATE
    } state_t;

    state_t       state, next_state;

    logic [7:0]   valid_q;
    logic [2:0]   tag_q  [8];
    logic [127:0] data_q [8];

    logic [2:0]   pc_tag;
    logic [2:0]   pc_index;
    logic [1:0]   pc_offset;
    logic         hit;
    logic         fill;
    logic         unused_pc_bits;

    assign pc_tag         = PC[9:7];
    assign pc_index       = PC[6:4];
    assign pc_offset      = PC[3:2];
    assign unused_pc_bits = ^{PC[31:10], PC[1:0]};

    assign hit         = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
    assign fill        = (state == S_MEM_READ) && !MEM_BUSYWAIT;
    assign MEM_ADDRESS = PC[9:4];

    always_comb begin
        INSTRUCTION = '0;
        if (RESET)
            INSTRUCTION = data_q[pc_index][{pc_offset, 5'd0} +: 32];
    end

    always_comb begin
        next_state = state;
        MEM_READ   = 1'b0;
        BUSYWAIT   = 1'b0;
        case (state)
            S_IDLE: begin
                BUSYWAIT = !hit;
                if (!hit)
                    next_state = S_MEM_READ;
            end
            S_MEM_READ: begin
                MEM_READ = 1'b1;
                BUSYWAIT = 1'b1;
                if (!MEM_BUSYWAIT)
                    next_state = S_UPDATE;
            end
            S_UPDATE: begin
                BUSYWAIT   = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
        // All lines are invalid in reset, so the IDLE miss must be masked here.
        if (!RESET)
            BUSYWAIT = 1'b0;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= S_IDLE;
            valid_q <= '0;
        end else begin
            state <= next_state;
            if (fill)
                valid_q[pc_index] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (fill) begin
            data_q[pc_index] <= MEM_READDATA;
            tag_q[pc_index]  <= pc_tag;
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// Randomised self-checking bench for instruction_cache against a tag/valid
// reference model and a latency-programmable block memory.
module tb_instruction_cache;

    logic         CLK;
    logic         RESET;
    logic [31:0]  PC;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    logic [127:0] mem [64];
    int unsigned  mem_lat;
    int unsigned  mem_cnt;

    bit           m_valid [8];
    logic [2:0]   m_tag   [8];

    int unsigned  n_checks;
    int unsigned  n_pass;

    instruction_cache dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (PC),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory holds its busy flag for mem_lat cycles after MEM_READ rises.
    always @(posedge CLK) begin
        if (MEM_READ) mem_cnt <= mem_cnt + 1;
        else          mem_cnt <= 0;
    end
    assign MEM_BUSYWAIT = MEM_READ && (mem_cnt < mem_lat);
    assign MEM_READDATA = mem[MEM_ADDRESS];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [127:0] blk;
        blk = mem[addr[9:4]];
        return blk[addr[3:2]*32 +: 32];
    endfunction

    // Called with PC already presented in the current cycle, sampled 2 time units after the edge.
    task automatic measure(input logic [31:0] addr, input int unsigned lat);
        int unsigned busy;
        int unsigned rd;
        bit          exp_hit;
        logic [2:0]  idx;
        busy    = 0;
        rd      = 0;
        idx     = addr[6:4];
        exp_hit = m_valid[idx] && (m_tag[idx] == addr[9:7]);
        while (BUSYWAIT && busy < 64) begin
            busy++;
            if (MEM_READ) begin
                rd++;
                check("mem_address", {26'd0, MEM_ADDRESS}, {26'd0, addr[9:4]});
            end
            @(posedge CLK);
            #2;
        end
        check("stall_cycles", busy, exp_hit ? 0 : lat + 3);
        check("mem_read_cycles", rd, exp_hit ? 0 : lat + 1);
        check("instruction", INSTRUCTION, mem_word(addr));
        m_valid[idx] = 1'b1;
        m_tag[idx]   = addr[9:7];
    endtask

    task automatic fetch(input logic [31:0] addr, input int unsigned lat);
        mem_lat = lat;
        @(posedge CLK);
        #1 PC = addr;
        #1;
        measure(addr, lat);
    endtask

    task automatic reset_model();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    endtask

    initial begin
        logic [31:0] addr;
        n_checks = 0;
        n_pass   = 0;
        mem_lat  = 4;
        PC       = 32'h0;
        RESET    = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        mem[0] = {32'h44, 32'h33, 32'h22, 32'h11};
        reset_model();

        // Cold start
        repeat (2) @(posedge CLK);
        #2;
        check("reset_busywait", {31'd0, BUSYWAIT}, 32'd0);
        check("reset_mem_read", {31'd0, MEM_READ}, 32'd0);
        check("reset_instruction", INSTRUCTION, 32'd0);
        @(posedge CLK);
        #1 RESET = 1'b1;
        PC = 32'h000;
        #1;
        measure(32'h000, 4);
        check("cold_word0", INSTRUCTION, 32'h11);

        // Same-block hits
        fetch(32'h004, 4);
        check("hit_word1", INSTRUCTION, 32'h22);
        fetch(32'h008, 4);
        check("hit_word2", INSTRUCTION, 32'h33);
        fetch(32'h00C, 4);
        check("hit_word3", INSTRUCTION, 32'h44);

        // Conflict miss, then restore
        fetch(32'h080, 2);
        fetch(32'h000, 3);
        check("conflict_restore", INSTRUCTION, 32'h11);

        // Zero-latency memory; neighbouring word then hits in block 7 tag 7
        fetch(32'h3F0, 0);
        fetch(32'h3FC, 0);

        // Aliasing: PC[31:10] ignored
        fetch(32'h400, 1);
        check("alias_word0", INSTRUCTION, 32'h11);

        // Reset in the 2nd MEM_READ cycle, asynchronous to CLK
        mem_lat = 6;
        @(posedge CLK);
        #1 PC = 32'h010;
        @(posedge CLK);
        @(posedge CLK);
        #3 RESET = 1'b0;
        #1;
        check("midfill_mem_read", {31'd0, MEM_READ}, 32'd0);
        check("midfill_busywait", {31'd0, BUSYWAIT}, 32'd0);
        check("midfill_instruction", INSTRUCTION, 32'd0);
        reset_model();
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;
        #1;
        measure(32'h010, 6);

        // Randomised fetches, two tags per index to mix hits and misses
        for (int n = 0; n < 60; n++) begin
            addr = ($urandom & 32'hFFFF_FC00)
                 | ($urandom_range(0, 1) << 7)
                 | ($urandom_range(0, 31) << 2)
                 | $urandom_range(0, 3);
            fetch(addr, $urandom_range(0, 5));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_cache.md
# instruction_cache

Direct-mapped, read-only instruction cache between the PC unit and the instruction memory. It takes the fetch address PC and returns the 32-bit instruction. On a miss it asserts BUSYWAIT, which stalls PC advance, fetches the whole 16-byte block over a read/busywait handshake, and then completes the fetch. The instruction address space is 1024 bytes: PC[9:0] is used and PC[31:10] is ignored.

## Interface
- Parameters: none. Geometry is fixed at 8 blocks × 16 bytes (4 words/block). Tag = PC[9:7], index = PC[6:4], word offset = PC[3:2]; PC[1:0] is ignored.
- CLK  in  1  clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- PC  in  32  fetch address from pc_unit; held stable by pc_unit while BUSYWAIT=1.
- INSTRUCTION  out  32  instruction word; valid only while BUSYWAIT=0.
- BUSYWAIT  out  1  stall request to pc_unit and the rest of the CPU.
- MEM_READ  out  1  block read request to instruction memory.
- MEM_ADDRESS  out  6  block address to memory, = PC[9:4].
- MEM_READDATA  in  128  block from memory; word0 is bits [31:0] and word3 is bits [127:96].
- MEM_BUSYWAIT  in  1  memory busy; MEM_READDATA is valid in the cycle MEM_BUSYWAIT is low while MEM_READ=1.

## Operation
- Storage per block: valid bit (1), tag (3 bits), data (128 bits). Only the valid bits require reset.
- Hit = valid[index] AND (tag[index] == PC[9:7]).
- INSTRUCTION = data[index] word selected by PC[3:2]. This output is combinational.
- FSM states:
  - IDLE:
    - MEM_READ=0.
    - BUSYWAIT = !hit.
    - On a miss, go to MEM_READ at the next edge.
  - MEM_READ:
    - MEM_READ=1, MEM_ADDRESS=PC[9:4], BUSYWAIT=1.
    - At an edge where MEM_BUSYWAIT is sampled 0: write MEM_READDATA to data[index], PC[9:7] to tag[index], and 1 to valid[index]; then go to UPDATE.
    - Otherwise stay in MEM_READ.
  - UPDATE:
    - MEM_READ=0, BUSYWAIT=1.
    - Go to IDLE unconditionally. This state gives one cycle for memory to release its handshake.
- On the IDLE re-entry after a fill, the lookup hits and BUSYWAIT falls in that cycle.
- A refill overwrites the block unconditionally. There is no dirty state and no write path.
- MEM_ADDRESS is driven as PC[9:4] in all states. It is only meaningful while MEM_READ=1.

## Timing
- Reset (RESET=0, at any time, including mid-fill):
  - All valid bits cleared, state forced to IDLE, MEM_READ=0.
  - Any in-flight fill is abandoned and no array write occurs.
  - While RESET=0: BUSYWAIT=0, INSTRUCTION=0.
  - On release, the first lookup misses because all blocks are invalid.
- Hit latency: 0 cycles. INSTRUCTION and BUSYWAIT=0 settle within the same cycle PC changes; pc_unit samples them at the next edge.
- Miss penalty with memory holding MEM_BUSYWAIT high for L cycles after MEM_READ rises:
  - 1 cycle IDLE (miss detected).
  - L+1 cycles in MEM_READ.
  - 1 cycle UPDATE.
  - BUSYWAIT is therefore high for L+3 consecutive cycles, then low in the following IDLE cycle.
- MEM_BUSYWAIT=0 in the first MEM_READ cycle (L=0) is legal. It gives a minimum stall of 3 cycles.
- PC changing while BUSYWAIT=1 is a protocol violation. Behaviour is undefined, but the FSM must still return to IDLE.
- Tag equality uses 3 bits only: PC 0x000 and PC 0x400 alias to the same entry and both hit.

## Test plan
- Cold start:
  - Stimulus: RESET low 2 cycles, release, PC=0x000, memory L=4, block 0 = {0x44,0x33,0x22,0x11} (word3..word0).
  - Response: BUSYWAIT=1 for exactly 7 cycles with MEM_READ=1 for 5 of them; MEM_ADDRESS=0x00; then BUSYWAIT=0 and INSTRUCTION=0x11.
- Same-block hits:
  - Stimulus: after the cold start, PC=0x004, 0x008, 0x00C on consecutive cycles.
  - Response: BUSYWAIT stays 0 and MEM_READ stays 0; INSTRUCTION is 0x22, 0x33, 0x44 in turn.
- Conflict miss:
  - Stimulus: PC=0x080 (same index 0, tag 1), then PC=0x000.
  - Response: both miss with L+3 stalls; MEM_ADDRESS is 0x08 then 0x00; the second fill restores 0x11 at PC=0x000.
- Zero-latency memory (L=0):
  - Stimulus: miss at PC=0x3F0.
  - Response: BUSYWAIT high exactly 3 cycles; MEM_ADDRESS=0x3F; tag 7 and index 7 are written.
- Reset mid-fill:
  - Stimulus: miss at PC=0x010; assert RESET in the 2nd MEM_READ cycle, asynchronous to CLK.
  - Response: MEM_READ drops immediately and BUSYWAIT=0; after release, PC=0x010 misses again, proving no partial write.
- Aliasing:
  - Stimulus: after filling PC=0x000, present PC=0x400.
  - Response: hit, BUSYWAIT=0, INSTRUCTION = word0 of block 0.
